// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin Req/Gnt arbiter sharing one DBus slave segment among NUM_MASTERS masters
// Ports: i_Clk/i_Rst_n clock and async active-low reset; i_M_* / o_M_* per-master DBus
// (request, registered one-hot grant, address, byte enables, strobes, data, stall);
// o_S_* / i_S_* shared slave bus driven by the current owner.
module dbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 30,
  parameter int HOLD_LIMIT  = 0
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic [NUM_MASTERS-1:0]        i_M_Req,
  output logic [NUM_MASTERS-1:0]        o_M_Gnt,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_M_Address,
  input  logic [NUM_MASTERS*4-1:0]      i_M_ByteEn,
  input  logic [NUM_MASTERS-1:0]        i_M_Read,
  input  logic [NUM_MASTERS-1:0]        i_M_Write,
  input  logic [NUM_MASTERS*32-1:0]     i_M_WriteData,
  output logic [NUM_MASTERS*32-1:0]     o_M_ReadData,
  output logic [NUM_MASTERS-1:0]        o_M_WaitRequest,
  output logic [ADDR_W-1:0]             o_S_Address,
  output logic [3:0]                    o_S_ByteEn,
  output logic                          o_S_Read,
  output logic                          o_S_Write,
  output logic [31:0]                   o_S_WriteData,
  input  logic [31:0]                   i_S_ReadData,
  input  logic                          i_S_WaitRequest
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int HW = $clog2(HOLD_LIMIT + 1) > 0 ? $clog2(HOLD_LIMIT + 1) : 1;
  typedef enum logic {IDLE, OWNED} state_t;
  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_last;
  logic [HW-1:0]          r_hold;
  logic                   w_owned;
  logic [NUM_MASTERS-1:0] w_others;
  logic                   w_busy;
  logic                   w_preempt;
  logic                   w_release;
  logic [IW:0]            w_pick;
  // {found, index} of the first requester strictly after last, wrapping upward
  function automatic logic [IW:0] rr_pick(input logic [NUM_MASTERS-1:0] req, input logic [IW-1:0] last);
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (req[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction
  assign w_owned   = r_state == OWNED;
  assign w_others  = i_M_Req & ~(NUM_MASTERS'(1) << r_owner);
  assign w_busy    = (i_M_Read[r_owner] | i_M_Write[r_owner]) & i_S_WaitRequest;
  assign w_preempt = HOLD_LIMIT != 0 && int'(r_hold) >= HOLD_LIMIT && |w_others;
  assign w_release = w_owned & ~w_busy & (~i_M_Req[r_owner] | w_preempt);
  // while owned, the owner is excluded so a preempted master sits out at least one cycle
  assign w_pick    = w_owned ? rr_pick(w_others, r_owner) : rr_pick(i_M_Req, r_last);
  assign o_M_Gnt   = r_gnt;
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_hold  <= '0;
    end else if (!w_owned) begin
      if (w_pick[IW]) begin
        r_state <= OWNED;
        r_owner <= w_pick[IW-1:0];
        r_gnt   <= NUM_MASTERS'(1) << w_pick[IW-1:0];
        r_hold  <= '0;
      end
    end else if (w_release) begin
      r_last  <= r_owner;
      r_hold  <= '0;
      r_state <= w_pick[IW] ? OWNED : IDLE;
      r_owner <= w_pick[IW] ? w_pick[IW-1:0] : r_owner;
      r_gnt   <= w_pick[IW] ? NUM_MASTERS'(1) << w_pick[IW-1:0] : '0;
    end else if (|w_others && int'(r_hold) < HOLD_LIMIT) begin
      r_hold <= r_hold + 1'b1;
    end
  end
  always_comb begin
    o_S_Address     = w_owned ? i_M_Address[r_owner*ADDR_W +: ADDR_W] : '0;
    o_S_ByteEn      = w_owned ? i_M_ByteEn[r_owner*4 +: 4] : '0;
    o_S_Read        = w_owned & i_M_Read[r_owner];
    o_S_Write       = w_owned & i_M_Write[r_owner];
    o_S_WriteData   = w_owned ? i_M_WriteData[r_owner*32 +: 32] : '0;
    o_M_ReadData    = '0;
    o_M_WaitRequest = '1;
    if (w_owned) begin
      o_M_ReadData[r_owner*32 +: 32] = i_S_ReadData;
      o_M_WaitRequest[r_owner]       = i_S_WaitRequest;
    end
  end
endmodule
